alu_exec_unit: RTL and testbench

- Integer execute stage directly downstream of the issue queue. Consumes one ALU micro-op per cycle through the isqIssueIf `in` modport (valid, alu_cmd, op1, op2, phys_rd).
- Computes the result in a registered E1 stage and buffers it in a small result FIFO. Drains the FIFO onto a valid/ready writeback/broadcast (CDB) port.
- isqIssueIf has no ready, so back-pressure returns to the issue queue as a separate `issue_stall` signal.

---
 rtl/alu_exec_unit.sv | 191 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Integer ALU execute stage: registered E1 operand stage, combinational ALU,
// small in-order result FIFO draining onto a valid/ready CDB port.
// Back-pressure to the issue queue is a separate issue_stall signal because
// the issue interface itself carries no ready.

package parameters;
   localparam int PHYS_REGS_ADDR_WIDTH = 6;
endpackage

package common;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SRL  = 4'd3,
      ALU_SRA  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_XOR  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_cmd_t;
endpackage

// Issue-queue to execute-unit micro-op handoff (no ready by design).
interface isqIssueIf;
   logic                                        valid;
   common::alu_cmd_t                            alu_cmd;
   logic [31:0]                                 op1;
   logic [31:0]                                 op2;
   logic [parameters::PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;

   modport in  (input  valid, alu_cmd, op1, op2, phys_rd);
   modport out (output valid, alu_cmd, op1, op2, phys_rd);
endinterface

module alu_exec_unit #(
   parameter int FIFO_DEPTH = 4,
   parameter int PREG_W     = parameters::PHYS_REGS_ADDR_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   isqIssueIf.in             isq,
   output logic              issue_stall,
   input  logic              flush,
   output logic              cdb_valid,
   input  logic              cdb_ready,
   output logic [PREG_W-1:0] cdb_phys_rd,
   output logic [31:0]       cdb_data
);
   import common::*;

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [PREG_W-1:0] rd;
      logic [31:0]       data;
   } result_t;

   // E1 stage registers
   logic              e1_valid;
   alu_cmd_t          e1_cmd;
   logic [31:0]       e1_op1;
   logic [31:0]       e1_op2;
   logic [PREG_W-1:0] e1_rd;

   // Result FIFO state
   result_t           mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   // Last value shown on the CDB, held while the FIFO is empty
   logic [PREG_W-1:0] last_rd;
   logic [31:0]       last_data;

   logic              issue_fire;
   logic              push;
   logic              pop;
   logic              fifo_nonempty;
   logic [31:0]       alu_result;
   logic [4:0]        shamt;
   logic [CNT_W:0]    occupancy;
   result_t           head;

   assign fifo_nonempty = (count != '0);
   assign head          = mem[rd_ptr];

   // Stall counts the op already in E1, since it will push next edge
   // regardless of what the CDB consumer does.
   assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, e1_valid};
   assign issue_stall = (occupancy >= (CNT_W+1)'(FIFO_DEPTH));

   // An issue seen while stalled or flushing is simply not captured.
   assign issue_fire = isq.valid && !issue_stall && !flush;
   assign push       = e1_valid && !flush;
   assign pop        = fifo_nonempty && cdb_ready && !flush;

   assign shamt = e1_op2[4:0];

   // Combinational ALU evaluated on the E1 operands.
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // alu_result unassigned, which would otherwise infer a latch.
      alu_result = '0;
      case (e1_cmd)
         ALU_ADD:  alu_result = e1_op1 + e1_op2;
         ALU_SUB:  alu_result = e1_op1 - e1_op2;
         ALU_SLL:  alu_result = e1_op1 << shamt;
         ALU_SRL:  alu_result = e1_op1 >> shamt;
         ALU_SRA:  alu_result = $unsigned($signed(e1_op1) >>> shamt);
         ALU_SLT:  alu_result = {31'd0, $signed(e1_op1) < $signed(e1_op2)};
         ALU_SLTU: alu_result = {31'd0, e1_op1 < e1_op2};
         ALU_XOR:  alu_result = e1_op1 ^ e1_op2;
         ALU_OR:   alu_result = e1_op1 | e1_op2;
         ALU_AND:  alu_result = e1_op1 & e1_op2;
         default:  alu_result = '0;
      endcase
   end

   // E1 capture: valid follows issue_fire every edge; operands load on fire.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         e1_valid <= 1'b0;
         e1_cmd   <= ALU_ADD;
         e1_op1   <= '0;
         e1_op2   <= '0;
         e1_rd    <= '0;
      end else begin
         e1_valid <= issue_fire;
         if (issue_fire) begin
            e1_cmd <= isq.alu_cmd;
            e1_op1 <= isq.op1;
            e1_op2 <= isq.op2;
            e1_rd  <= isq.phys_rd;
         end
      end
   end

   // FIFO storage write at the tail.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; validity is tracked solely by
      // count/pointers, so stale contents are never observed as valid.
      if (push) begin
         mem[wr_ptr] <= '{rd: e1_rd, data: alu_result};
      end
   end

   // FIFO pointers and occupancy; flush empties the queue outright.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Remember the head shown on the CDB so the bus holds it once empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_rd   <= '0;
         last_data <= '0;
      end else if (fifo_nonempty) begin
         last_rd   <= head.rd;
         last_data <= head.data;
      end
   end

   // CDB port driven straight from the FIFO head, no bypass from E1.
   always_comb begin
      cdb_valid   = fifo_nonempty;
      cdb_phys_rd = fifo_nonempty ? head.rd   : last_rd;
      cdb_data    = fifo_nonempty ? head.data : last_data;
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (FIFO_DEPTH = 4).
module tb_alu_exec_unit;
   import common::*;

   localparam int RW = parameters::PHYS_REGS_ADDR_WIDTH;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          cdb_ready;
   logic          issue_stall;
   logic          cdb_valid;
   logic [RW-1:0] cdb_phys_rd;
   logic [31:0]   cdb_data;

   int checks = 0;
   int errors = 0;

   // Stream vectors used by run_stream
   alu_cmd_t      s_cmd [16];
   logic [31:0]   s_a   [16];
   logic [31:0]   s_b   [16];
   logic [31:0]   s_exp [16];
   logic [RW-1:0] s_rd  [16];

   isqIssueIf isq_if ();

   alu_exec_unit #(.FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .isq         (isq_if),
      .issue_stall (issue_stall),
      .flush       (flush),
      .cdb_valid   (cdb_valid),
      .cdb_ready   (cdb_ready),
      .cdb_phys_rd (cdb_phys_rd),
      .cdb_data    (cdb_data)
   );

   always #5 clk = ~clk;

   // A legal issue queue never asserts valid while stalled.
   always @(negedge clk) begin
      if (!rst && isq_if.valid && issue_stall) begin
         errors++;
         $display("FAIL protocol: issue valid=1 while issue_stall=1 at %0t", $time);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_issue(input alu_cmd_t c, input logic [31:0] a, input logic [31:0] b,
                            input logic [RW-1:0] rd);
      isq_if.valid   = 1'b1;
      isq_if.alu_cmd = c;
      isq_if.op1     = a;
      isq_if.op2     = b;
      isq_if.phys_rd = rd;
   endtask

   task automatic clr_issue();
      isq_if.valid = 1'b0;
   endtask

   task automatic load(input int i, input alu_cmd_t c, input logic [31:0] a, input logic [31:0] b,
                       input logic [RW-1:0] rd, input logic [31:0] e);
      s_cmd[i] = c; s_a[i] = a; s_b[i] = b; s_rd[i] = rd; s_exp[i] = e;
   endtask

   // Issue n loaded ops whenever not stalled, compare each popped result in order.
   task automatic run_stream(input string tag, input int n, input int budget, input bit toggle_ready);
      int i = 0;
      int o = 0;
      int cyc = 0;
      while (o < n && cyc < budget) begin
         cdb_ready = toggle_ready ? ((cyc % 3) != 2) : 1'b1;
         if (cdb_valid && cdb_ready) begin
            checks++;
            if ({cdb_phys_rd, cdb_data} !== {s_rd[o], s_exp[o]})
               begin
                  errors++;
                  $display("FAIL %s[%0d]: got rd=%0d data=%h, want rd=%0d data=%h",
                           tag, o, cdb_phys_rd, cdb_data, s_rd[o], s_exp[o]);
               end
            o++;
         end
         if (i < n && !issue_stall) begin
            set_issue(s_cmd[i], s_a[i], s_b[i], s_rd[i]);
            i++;
         end else begin
            clr_issue();
         end
         tick();
         cyc++;
      end
      clr_issue();
      checks++;
      if (o != n) begin
         errors++;
         $display("FAIL %s_timeout: got %0d results, want %0d", tag, o, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; flush = 1'b0; cdb_ready = 1'b0;
      isq_if.valid = 1'b0; isq_if.alu_cmd = ALU_ADD; isq_if.op1 = '0; isq_if.op2 = '0;
      isq_if.phys_rd = '0;
      #1 rst = 1'b1;
      #2;
      checks++;
      if ({cdb_valid, issue_stall, cdb_phys_rd, cdb_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b stall=%b rd=%0d data=%h, want all 0",
                  cdb_valid, issue_stall, cdb_phys_rd, cdb_data);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (cdb_valid !== 1'b0 || issue_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got valid=%b stall=%b, want 0 0", cdb_valid, issue_stall);
      end
   endtask

   task automatic test_latency();
      cdb_ready = 1'b1;
      set_issue(ALU_ADD, 32'd5, 32'd7, RW'(3));
      tick();                                  // edge N sampled the issue
      clr_issue();
      checks++;
      if (cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL lat_n1_valid: got %b, want 0", cdb_valid);
      end
      tick();                                  // cycle N+2
      checks++;
      if (cdb_valid !== 1'b1 || cdb_data !== 32'd12 || cdb_phys_rd !== RW'(3)) begin
         errors++;
         $display("FAIL lat_n2_result: got valid=%b rd=%0d data=%h, want 1 3 0000000c",
                  cdb_valid, cdb_phys_rd, cdb_data);
      end
      tick();                                  // cycle N+3
      checks++;
      if (cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL lat_n3_valid: got %b, want 0", cdb_valid);
      end
   endtask

   task automatic test_sweep();
      load(0,  ALU_SUB,  32'd3,         32'd5,        RW'(1),  32'hFFFF_FFFE);
      load(1,  ALU_SRA,  32'h8000_0000, 32'd4,        RW'(2),  32'hF800_0000);
      load(2,  ALU_SRL,  32'h8000_0000, 32'd4,        RW'(3),  32'h0800_0000);
      load(3,  ALU_SLL,  32'd1,         32'h21,       RW'(4),  32'd2);
      load(4,  ALU_SLT,  32'hFFFF_FFFF, 32'd1,        RW'(5),  32'd1);
      load(5,  ALU_SLTU, 32'hFFFF_FFFF, 32'd1,        RW'(6),  32'd0);
      load(6,  ALU_AND,  32'hF0F0,      32'h0FF0,     RW'(7),  32'h00F0);
      load(7,  ALU_OR,   32'hF0F0,      32'h0FF0,     RW'(8),  32'hFFF0);
      load(8,  ALU_XOR,  32'hF0F0,      32'h0FF0,     RW'(9),  32'hFF00);
      load(9,  ALU_ADD,  32'hFFFF_FFFF, 32'd1,        RW'(10), 32'd0);
      load(10, ALU_SRA,  32'h8000_0000, 32'h3F,       RW'(11), 32'hFFFF_FFFF);
      load(11, ALU_SLT,  32'd1,         32'hFFFF_FFFF, RW'(12), 32'd0);
      load(12, ALU_SLTU, 32'd1,         32'hFFFF_FFFF, RW'(13), 32'd1);
      load(13, alu_cmd_t'(4'hC), 32'd5, 32'd5,        RW'(14), 32'd0);
      load(14, ALU_SRA,  32'h7FFF_FFF0, 32'd4,        RW'(15), 32'h07FF_FFFF);
      run_stream("sweep", 15, 60, 1'b0);
   endtask

   task automatic test_back_pressure();
      int accepted = 0;
      cdb_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (!issue_stall) begin
            set_issue(ALU_ADD, 32'(accepted * 3), 32'h1000, RW'(20 + accepted));
            accepted++;
         end else begin
            clr_issue();
         end
         tick();
      end
      clr_issue();
      checks++;
      if (accepted != 4) begin
         errors++;
         $display("FAIL bp_accepted: got %0d, want 4", accepted);
      end
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (issue_stall !== 1'b1 || cdb_valid !== 1'b1 || cdb_data !== 32'h1000 ||
             cdb_phys_rd !== RW'(20)) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got stall=%b valid=%b rd=%0d data=%h, want 1 1 20 00001000",
                     c, issue_stall, cdb_valid, cdb_phys_rd, cdb_data);
         end
         tick();
      end
      cdb_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (cdb_valid !== 1'b1 || cdb_data !== 32'h1000 + 32'(k * 3) || cdb_phys_rd !== RW'(20 + k)) begin
            errors++;
            $display("FAIL bp_drain[%0d]: got valid=%b rd=%0d data=%h, want 1 %0d %h",
                     k, cdb_valid, cdb_phys_rd, cdb_data, 20 + k, 32'h1000 + 32'(k * 3));
         end
         tick();
         if (k == 0) begin
            checks++;
            if (issue_stall !== 1'b0) begin
               errors++;
               $display("FAIL bp_stall_drop: got %b, want 0", issue_stall);
            end
         end
      end
      checks++;
      if (cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty: got valid=%b, want 0", cdb_valid);
      end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] exp_d [3];
      cdb_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_issue(ALU_ADD, 32'h2000 + 32'(k), 32'd0, RW'(30 + k));
         tick();
      end
      clr_issue();
      // Three queued plus op3 in E1: occupancy at the limit.
      checks++;
      if (issue_stall !== 1'b1 || cdb_data !== 32'h2000) begin
         errors++;
         $display("FAIL fpp_setup: got stall=%b data=%h, want 1 00002000", issue_stall, cdb_data);
      end
      cdb_ready = 1'b1;                        // pop op0 while op3 pushes
      tick();
      cdb_ready = 1'b0;
      checks++;
      if (cdb_valid !== 1'b1 || cdb_data !== 32'h2001 || issue_stall !== 1'b0) begin
         errors++;
         $display("FAIL fpp_after_pulse: got valid=%b data=%h stall=%b, want 1 00002001 0",
                  cdb_valid, cdb_data, issue_stall);
      end
      set_issue(ALU_ADD, 32'h2004, 32'd0, RW'(34));
      tick();
      clr_issue();
      tick();                                  // FIFO now holds four entries
      checks++;
      if (issue_stall !== 1'b1) begin
         errors++;
         $display("FAIL fpp_full_stall: got %b, want 1", issue_stall);
      end
      cdb_ready = 1'b1;
      tick();                                  // pop op1
      exp_d[0] = 32'h2002; exp_d[1] = 32'h2003; exp_d[2] = 32'h2004;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (cdb_valid !== 1'b1 || cdb_data !== exp_d[k] || cdb_phys_rd !== RW'(32 + k)) begin
            errors++;
            $display("FAIL fpp_order[%0d]: got valid=%b rd=%0d data=%h, want 1 %0d %h",
                     k, cdb_valid, cdb_phys_rd, cdb_data, 32 + k, exp_d[k]);
         end
         tick();
      end
      checks++;
      if (cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL fpp_empty: got valid=%b, want 0", cdb_valid);
      end
   endtask

   task automatic test_flush();
      cdb_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_issue(ALU_OR, 32'h5000, 32'(k), RW'(40 + k));
         tick();
      end
      // Two queued, op2 in E1; issue op3 in the same cycle as flush.
      set_issue(ALU_OR, 32'h5000, 32'd3, RW'(43));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      clr_issue();
      checks++;
      if (cdb_valid !== 1'b0 || issue_stall !== 1'b0) begin
         errors++;
         $display("FAIL flush_next: got valid=%b stall=%b, want 0 0", cdb_valid, issue_stall);
      end
      tick();
      checks++;
      if (cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_dropped: got valid=%b, want 0", cdb_valid);
      end
      cdb_ready = 1'b1;
      set_issue(ALU_ADD, 32'd1, 32'd1, RW'(7));
      tick();
      clr_issue();
      checks++;
      if (cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_lat_n1: got valid=%b, want 0", cdb_valid);
      end
      tick();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_data !== 32'd2 || cdb_phys_rd !== RW'(7)) begin
         errors++;
         $display("FAIL flush_lat_n2: got valid=%b rd=%0d data=%h, want 1 7 00000002",
                  cdb_valid, cdb_phys_rd, cdb_data);
      end
      tick();
   endtask

   task automatic test_async_reset();
      cdb_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (!issue_stall) set_issue(ALU_XOR, 32'hAAAA_0000, 32'(c), RW'(50 + c));
         else              clr_issue();
         tick();
      end
      clr_issue();
      checks++;
      if (cdb_valid !== 1'b1 || issue_stall !== 1'b1) begin
         errors++;
         $display("FAIL ar_full: got valid=%b stall=%b, want 1 1", cdb_valid, issue_stall);
      end
      #2 rst = 1'b1;                           // mid-cycle, well before next edge
      #1;
      checks++;
      if ({cdb_valid, issue_stall, cdb_phys_rd, cdb_data} !== '0) begin
         errors++;
         $display("FAIL ar_immediate: got valid=%b stall=%b rd=%0d data=%h, want all 0",
                  cdb_valid, issue_stall, cdb_phys_rd, cdb_data);
      end
      #2 rst = 1'b0;
      tick();
      for (int k = 0; k < 10; k++)
         load(k, ALU_ADD, 32'(k), 32'(k * 256), RW'(40 + k), 32'(k * 257));
      run_stream("wrap", 10, 80, 1'b1);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_sweep();
      test_back_pressure();
      test_full_push_pop();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
